shift_exec_stage: RTL and testbench

- Multi-cycle execute-stage wrapper around the combinational 32-bit shifter (Shiftop 00=sll, 10=srl, 11=sra, 01 yields 0).
- Accepts decoded R-type shift instructions from the issue logic over a valid/ready handshake, and forms the shifter's A, B and Shiftop.
- Registers the shifter's Result and hands it to writeback over a second valid/ready handshake.
- With the optional feature compiled in, implements rotate-right as two passes through the same shifter.

---
 rtl/shift_exec_stage.sv | 219 +++++++++++++++++++++
 tb/tb_shift_exec_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
//
// Multi-cycle execute stage wrapped around an external combinational 32-bit
// shifter (sh_op: 00 = sll, 10 = srl, 11 = sra, 01 = constant zero).
// It accepts decoded R-type shift instructions over a valid/ready handshake,
// drives the shifter from registered operands and returns the registered
// result to writeback over a second valid/ready handshake.
//
// Optional feature macro: SHIFT_ROTATE_EN
//   When defined, rotr (srl encoding with instr[21]=1) and rotrv (srlv
//   encoding with instr[6]=1) are executed as two passes through the shifter:
//   a right shift by amt, then a left shift by (32-amt) mod 32, ORed together.
//   When undefined, those encodings execute as plain srl/srlv.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  issue handshake
//   in_instr        instruction word: [15:11] rd, [10:6] shamt, [5:0] funct
//   in_rs_data      variable shift amount operand
//   in_rt_data      value to be shifted
//   sh_A/sh_B/sh_op operands to the external shifter
//   sh_result       shifter result (combinational, same cycle)
//   out_valid/ready writeback handshake
//   out_wdata       shift result (0 for illegal funct)
//   out_waddr       destination register rd
//   out_illegal     funct was not a supported shift, qualified by out_valid
// -----------------------------------------------------------------------------
module shift_exec_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs_data,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  output logic [DATA_WIDTH-1:0] sh_A,
  output logic [DATA_WIDTH-1:0] sh_B,
  output logic [1:0]            sh_op,
  input  logic [DATA_WIDTH-1:0] sh_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic [REG_AW-1:0]     out_waddr,
  output logic                  out_illegal
);

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_ZERO = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;
  localparam logic [1:0] OP_SRA  = 2'b11;

`ifdef SHIFT_ROTATE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2, ROT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] a_q, b_q, wdata_q;
  logic [1:0]            op_q;
  logic [REG_AW-1:0]     waddr_q;
  logic                  illegal_q;
`ifdef SHIFT_ROTATE_EN
  logic                  rot_q;
  logic [DATA_WIDTH-1:0] tmp_q;
`endif

  // Instruction fields.
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [REG_AW-1:0] rd;
  assign funct = in_instr[5:0];
  assign shamt = in_instr[10:6];
  assign rd    = in_instr[15:11];

  // Fields of the instruction word this stage never looks at.
  logic unused_instr_bits;
  assign unused_instr_bits = ^in_instr[31:16];

  logic accept;
  assign in_ready = rst_n && ((state_q == IDLE) || (state_q == DONE && out_ready));
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Decode of the incoming instruction; registered only on accept.
  // ---------------------------------------------------------------------------
  logic [1:0]            dec_op;
  logic [DATA_WIDTH-1:0] dec_b;
  logic                  dec_illegal;
  logic                  dec_rot;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dec_op      = OP_ZERO;
    dec_b       = '0;
    dec_illegal = 1'b0;
    dec_rot     = 1'b0;
    case (funct)
      F_SLL:  begin dec_op = OP_SLL; dec_b = {{(DATA_WIDTH-5){1'b0}}, shamt}; end
      F_SRL:  begin
        dec_op = OP_SRL;
        dec_b  = {{(DATA_WIDTH-5){1'b0}}, shamt};
`ifdef SHIFT_ROTATE_EN
        dec_rot = in_instr[21];
`endif
      end
      F_SRA:  begin dec_op = OP_SRA; dec_b = {{(DATA_WIDTH-5){1'b0}}, shamt}; end
      F_SLLV: begin dec_op = OP_SLL; dec_b = in_rs_data; end
      F_SRLV: begin
        dec_op = OP_SRL;
        dec_b  = in_rs_data;
`ifdef SHIFT_ROTATE_EN
        dec_rot = in_instr[6];
`endif
      end
      F_SRAV: begin dec_op = OP_SRA; dec_b = in_rs_data; end
      default: dec_illegal = 1'b1;
    endcase
  end

`ifndef SHIFT_ROTATE_EN
  logic unused_dec_rot;
  assign unused_dec_rot = dec_rot;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = EXEC;
`ifdef SHIFT_ROTATE_EN
      EXEC: state_d = rot_q ? ROT : DONE;
      ROT:  state_d = DONE;
`else
      EXEC: state_d = DONE;
`endif
      DONE: if (out_ready) state_d = in_valid ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 2'b00;
      wdata_q   <= '0;
      waddr_q   <= '0;
      illegal_q <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      rot_q     <= 1'b0;
      tmp_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q       <= in_rt_data;
        b_q       <= dec_b;
        op_q      <= dec_op;
        waddr_q   <= rd;
        illegal_q <= dec_illegal;
`ifdef SHIFT_ROTATE_EN
        rot_q     <= dec_rot;
`endif
      end
      if (state_q == EXEC) begin
`ifdef SHIFT_ROTATE_EN
        if (rot_q) begin
          // First pass done: keep the right-shifted part and retarget the
          // shifter to a left shift by (32 - amt) mod 32 for the second pass.
          tmp_q <= sh_result;
          op_q  <= OP_SLL;
          b_q   <= {{(DATA_WIDTH-5){1'b0}}, 5'd0 - b_q[4:0]};
        end else begin
          wdata_q <= illegal_q ? '0 : sh_result;
        end
`else
        wdata_q <= illegal_q ? '0 : sh_result;
`endif
      end
`ifdef SHIFT_ROTATE_EN
      if (state_q == ROT) wdata_q <= tmp_q | sh_result;
`endif
    end
  end

  // The shifter is driven straight from the latched operands; outside EXEC/ROT
  // these simply hold their last values.
  assign sh_A  = a_q;
  assign sh_B  = b_q;
  assign sh_op = op_q;

  assign out_valid   = (state_q == DONE);
  assign out_wdata   = wdata_q;
  assign out_waddr   = waddr_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_exec_stage
//
// Directed testbench for shift_exec_stage. A behavioural model of the external
// combinational shifter closes the sh_* / sh_result loop. Expected values are
// hand-computed constants; rotate expectations depend on SHIFT_ROTATE_EN.
// -----------------------------------------------------------------------------
module tb_shift_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [31:0] sh_A;
  logic [31:0] sh_B;
  logic [1:0]  sh_op;
  logic [31:0] sh_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_wdata;
  logic [4:0]  out_waddr;
  logic        out_illegal;

  int n_cmp = 0;
  int n_err = 0;

  shift_exec_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rs_data (in_rs_data),
    .in_rt_data (in_rt_data),
    .sh_A       (sh_A),
    .sh_B       (sh_B),
    .sh_op      (sh_op),
    .sh_result  (sh_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_wdata  (out_wdata),
    .out_waddr  (out_waddr),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shifter model.
  always_comb begin
    sh_result = 32'h0;
    case (sh_op)
      2'b00: sh_result = sh_A << sh_B[4:0];
      2'b10: sh_result = sh_A >> sh_B[4:0];
      2'b11: sh_result = $unsigned($signed(sh_A) >>> sh_B[4:0]);
      default: sh_result = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] funct, input logic [4:0] rs,
                                     input logic [4:0] rd, input logic [4:0] shamt);
    return {6'b0, rs, 5'b0, rd, shamt, funct};
  endfunction

  // Issue one instruction from IDLE, check the shifter drive in EXEC, the
  // latency to out_valid, the result fields, then drain it.
  task automatic run_op(input string tag, input logic [31:0] instr,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [1:0] exp_op, input logic chk_b,
                        input logic [31:0] exp_b, input logic [31:0] exp_data,
                        input logic [4:0] exp_addr, input logic exp_ill, input int lat);
    @(negedge clk);
    check({tag, ".in_ready_idle"}, in_ready, 1'b1);
    in_valid = 1'b1; in_instr = instr; in_rs_data = rs; in_rt_data = rt;
    @(posedge clk); #1;
    // Scramble inputs: they must have been sampled on the accept edge.
    in_valid = 1'b0; in_instr = 32'hFFFF_FFFF; in_rs_data = 32'h1357_9BDF; in_rt_data = 32'hDEAD_BEEF;
    check({tag, ".in_ready_exec"}, in_ready, 1'b0);
    check({tag, ".valid_exec"}, out_valid, 1'b0);
    check({tag, ".sh_op"}, sh_op, exp_op);
    check({tag, ".sh_A"}, sh_A, rt);
    if (chk_b) check({tag, ".sh_B"}, sh_B, exp_b);
    for (int i = 2; i < lat; i++) begin
      @(posedge clk); #1;
      check({tag, ".valid_rot"}, out_valid, 1'b0);
    end
    @(posedge clk); #1;
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".wdata"}, out_wdata, exp_data);
    check({tag, ".waddr"}, out_waddr, exp_addr);
    check({tag, ".illegal"}, out_illegal, exp_ill);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".valid_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_rs_data = '0; in_rt_data = '0;
    out_ready = 1'b0;

    // Reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready_low", in_ready, 1'b0);
    check("rst.valid_low", out_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.valid", out_valid, 1'b0);
    check("rst.wdata", out_wdata, 32'h0);
    check("rst.waddr", out_waddr, 5'd0);
    check("rst.illegal", out_illegal, 1'b0);

    // sll rd=3, rt=1, shamt=4.
    run_op("sll", mk(6'b000000, 5'd0, 5'd3, 5'd4), 32'h0, 32'h0000_0001,
           2'b00, 1'b1, 32'd4, 32'h0000_0010, 5'd3, 1'b0, 2);
    // sra by 31, then srav with full rs passed through on sh_B.
    run_op("sra", mk(6'b000011, 5'd0, 5'd4, 5'd31), 32'h0, 32'h8000_0000,
           2'b11, 1'b1, 32'd31, 32'hFFFF_FFFF, 5'd4, 1'b0, 2);
    run_op("srav", mk(6'b000111, 5'd0, 5'd6, 5'd0), 32'hFFFF_FFE4, 32'h8000_0000,
           2'b11, 1'b1, 32'hFFFF_FFE4, 32'hF800_0000, 5'd6, 1'b0, 2);

    // srl result held under writeback backpressure, then a back-to-back accept.
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk(6'b000010, 5'd0, 5'd7, 5'd4);
    in_rs_data = 32'h0; in_rt_data = 32'hF000_0000;
    @(posedge clk); #1;
    in_instr = mk(6'b000100, 5'd0, 5'd9, 5'd0); in_rs_data = 32'h0000_0021; in_rt_data = 32'h0000_0003;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("hold.valid", out_valid, 1'b1);
      check("hold.wdata", out_wdata, 32'h0F00_0000);
      check("hold.waddr", out_waddr, 5'd7);
      check("hold.in_ready", in_ready, 1'b0);
    end
    @(negedge clk); out_ready = 1'b1; #1;
    check("b2b.in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; in_rt_data = 32'hDEAD_BEEF;
    check("b2b.valid_exec", out_valid, 1'b0);
    check("b2b.in_ready_exec", in_ready, 1'b0);
    check("b2b.sh_A", sh_A, 32'h0000_0003);
    @(posedge clk); #1;
    check("b2b.valid", out_valid, 1'b1);
    check("b2b.wdata", out_wdata, 32'h0000_0006);
    check("b2b.waddr", out_waddr, 5'd9);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("b2b.drained", out_valid, 1'b0);

    // Illegal funct (add).
    run_op("add", mk(6'b100000, 5'd0, 5'd10, 5'd3), 32'h5, 32'h1234_5678,
           2'b01, 1'b0, 32'h0, 32'h0000_0000, 5'd10, 1'b1, 2);

    // Reset pulsed in EXEC: nothing is emitted afterwards.
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk(6'b000000, 5'd0, 5'd5, 5'd1); in_rt_data = 32'h1;
    @(posedge clk); #1; in_valid = 1'b0;
    #2 rst_n = 1'b0; #1;
    check("rst_exec.valid", out_valid, 1'b0);
    check("rst_exec.in_ready_low", in_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst_exec.in_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_exec.no_result", out_valid, 1'b0);
    end

    // Reset pulsed in DONE: out_valid drops at once.
    @(negedge clk);
    in_valid = 1'b1; in_instr = mk(6'b000000, 5'd0, 5'd5, 5'd1); in_rt_data = 32'h1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_done.valid_before", out_valid, 1'b1);
    #2 rst_n = 1'b0; #1;
    check("rst_done.valid", out_valid, 1'b0);
    check("rst_done.wdata", out_wdata, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Rotate encodings (srl/srlv with the rotate select bit set).
`ifdef SHIFT_ROTATE_EN
    run_op("rotr8", mk(6'b000010, 5'd1, 5'd11, 5'd8), 32'h0, 32'h1234_5678,
           2'b10, 1'b1, 32'd8, 32'h7812_3456, 5'd11, 1'b0, 3);
    run_op("rotr0", mk(6'b000010, 5'd1, 5'd12, 5'd0), 32'h0, 32'h1234_5678,
           2'b10, 1'b1, 32'd0, 32'h1234_5678, 5'd12, 1'b0, 3);
    run_op("rotrv4", mk(6'b000110, 5'd0, 5'd13, 5'd1), 32'h0000_0004, 32'h1234_5678,
           2'b10, 1'b1, 32'd4, 32'h8123_4567, 5'd13, 1'b0, 3);
`else
    run_op("rotr8", mk(6'b000010, 5'd1, 5'd11, 5'd8), 32'h0, 32'h1234_5678,
           2'b10, 1'b1, 32'd8, 32'h0012_3456, 5'd11, 1'b0, 2);
    run_op("rotr0", mk(6'b000010, 5'd1, 5'd12, 5'd0), 32'h0, 32'h1234_5678,
           2'b10, 1'b1, 32'd0, 32'h1234_5678, 5'd12, 1'b0, 2);
    run_op("rotrv4", mk(6'b000110, 5'd0, 5'd13, 5'd1), 32'h0000_0004, 32'h1234_5678,
           2'b10, 1'b1, 32'd4, 32'h0123_4567, 5'd13, 1'b0, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
